// File: rtl/pe_relay_fifo3.sv
// Idle PE tile that relays east/north/south traffic through three independent
// valid/ready FIFOs, so an unused grid slot can absorb back-pressure and bursts.

module pe_relay_chan #(
    parameter int WIDTH    = 132,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_run,
    input  logic [WIDTH-1:0]    i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [WIDTH-1:0]    o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [CNT_BITS-1:0] o_count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0] ZERO_CNT = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] ONE_CNT  = CNT_BITS'(1);
    localparam logic [PTR_BITS-1:0] ONE_PTR  = PTR_BITS'(1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wptr;
    logic [PTR_BITS-1:0] r_rptr;
    logic [CNT_BITS-1:0] r_count;
    logic [WIDTH-1:0]    r_last;

    logic                w_ready;
    logic                w_valid;
    logic                w_push;
    logic                w_pop;
    logic [WIDTH-1:0]    w_data;

    // Handshake qualifiers depend only on registered occupancy and the run enable.
    always_comb begin
        w_ready = i_run && (r_count != FULL_CNT);
        w_valid = i_run && (r_count != ZERO_CNT);
        w_push  = i_valid && w_ready;
        w_pop   = w_valid && i_ready;
    end

    // Storage array; left unreset since occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers, occupancy and the last-popped word; reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {PTR_BITS{1'b0}};
            r_rptr  <= {PTR_BITS{1'b0}};
            r_count <= ZERO_CNT;
            r_last  <= {WIDTH{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ONE_PTR;
                r_last <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // An empty FIFO keeps presenting the most recently popped word.
    always_comb begin
        if (r_count != ZERO_CNT) begin
            w_data = r_mem[r_rptr];
        end else begin
            w_data = r_last;
        end
    end

    // Output drive.
    always_comb begin
        o_ready = w_ready;
        o_valid = w_valid;
        o_data  = w_data;
        o_count = r_count;
    end

endmodule

module pe_relay_fifo3 #(
    parameter int EAST_WIDTH  = 132,
    parameter int NORTH_WIDTH = 164,
    parameter int SOUTH_WIDTH = 164,
    parameter int DEPTH       = 4,
    parameter int CNT_BITS    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ap_start,

    input  logic [EAST_WIDTH-1:0]  in_from_east,
    input  logic                   in_east_valid,
    output logic                   in_east_ready,
    output logic [EAST_WIDTH-1:0]  out_to_east,
    output logic                   out_east_valid,
    input  logic                   out_east_ready,

    input  logic [NORTH_WIDTH-1:0] in_from_north,
    input  logic                   in_north_valid,
    output logic                   in_north_ready,
    output logic [NORTH_WIDTH-1:0] out_to_north,
    output logic                   out_north_valid,
    input  logic                   out_north_ready,

    input  logic [SOUTH_WIDTH-1:0] in_from_south,
    input  logic                   in_south_valid,
    output logic                   in_south_ready,
    output logic [SOUTH_WIDTH-1:0] out_to_south,
    output logic                   out_south_valid,
    input  logic                   out_south_ready,

    output logic [CNT_BITS-1:0]    east_count,
    output logic [CNT_BITS-1:0]    north_count,
    output logic [CNT_BITS-1:0]    south_count,
    output logic                   busy
);

    logic [CNT_BITS-1:0] w_east_count;
    logic [CNT_BITS-1:0] w_north_count;
    logic [CNT_BITS-1:0] w_south_count;

    pe_relay_chan #(
        .WIDTH    (EAST_WIDTH),
        .DEPTH    (DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_east (
        .clk     (clk),
        .reset   (reset),
        .i_run   (ap_start),
        .i_data  (in_from_east),
        .i_valid (in_east_valid),
        .o_ready (in_east_ready),
        .o_data  (out_to_east),
        .o_valid (out_east_valid),
        .i_ready (out_east_ready),
        .o_count (w_east_count)
    );

    pe_relay_chan #(
        .WIDTH    (NORTH_WIDTH),
        .DEPTH    (DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_north (
        .clk     (clk),
        .reset   (reset),
        .i_run   (ap_start),
        .i_data  (in_from_north),
        .i_valid (in_north_valid),
        .o_ready (in_north_ready),
        .o_data  (out_to_north),
        .o_valid (out_north_valid),
        .i_ready (out_north_ready),
        .o_count (w_north_count)
    );

    pe_relay_chan #(
        .WIDTH    (SOUTH_WIDTH),
        .DEPTH    (DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_south (
        .clk     (clk),
        .reset   (reset),
        .i_run   (ap_start),
        .i_data  (in_from_south),
        .i_valid (in_south_valid),
        .o_ready (in_south_ready),
        .o_data  (out_to_south),
        .o_valid (out_south_valid),
        .i_ready (out_south_ready),
        .o_count (w_south_count)
    );

    // Busy tracks stored data even while ap_start is low.
    always_comb begin
        east_count  = w_east_count;
        north_count = w_north_count;
        south_count = w_south_count;
        busy        = (w_east_count != {CNT_BITS{1'b0}}) ||
                      (w_north_count != {CNT_BITS{1'b0}}) ||
                      (w_south_count != {CNT_BITS{1'b0}});
    end

endmodule

// File: tb/tb_pe_relay_fifo3.sv
// Directed bench for pe_relay_fifo3: latency, full/wrap, concurrent push/pop,
// channel isolation, ap_start freeze and reset discard.

module tb_pe_relay_fifo3;

    localparam int EW = 132;
    localparam int NW = 164;
    localparam int SW = 164;
    localparam int CB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          ap_start;
    logic [EW-1:0] in_from_east;
    logic          in_east_valid;
    logic          in_east_ready;
    logic [EW-1:0] out_to_east;
    logic          out_east_valid;
    logic          out_east_ready;
    logic [NW-1:0] in_from_north;
    logic          in_north_valid;
    logic          in_north_ready;
    logic [NW-1:0] out_to_north;
    logic          out_north_valid;
    logic          out_north_ready;
    logic [SW-1:0] in_from_south;
    logic          in_south_valid;
    logic          in_south_ready;
    logic [SW-1:0] out_to_south;
    logic          out_south_valid;
    logic          out_south_ready;
    logic [CB-1:0] east_count;
    logic [CB-1:0] north_count;
    logic [CB-1:0] south_count;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_relay_fifo3 dut (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .in_from_east(in_from_east), .in_east_valid(in_east_valid), .in_east_ready(in_east_ready),
        .out_to_east(out_to_east), .out_east_valid(out_east_valid), .out_east_ready(out_east_ready),
        .in_from_north(in_from_north), .in_north_valid(in_north_valid), .in_north_ready(in_north_ready),
        .out_to_north(out_to_north), .out_north_valid(out_north_valid), .out_north_ready(out_north_ready),
        .in_from_south(in_from_south), .in_south_valid(in_south_valid), .in_south_ready(in_south_ready),
        .out_to_south(out_to_south), .out_south_valid(out_south_valid), .out_south_ready(out_south_ready),
        .east_count(east_count), .north_count(north_count), .south_count(south_count), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are applied and outputs sampled 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [255:0] got [$];

    initial begin
        reset = 1'b1; ap_start = 1'b0;
        in_from_east = '0; in_east_valid = 1'b0; out_east_ready = 1'b0;
        in_from_north = '0; in_north_valid = 1'b0; out_north_ready = 1'b0;
        in_from_south = '0; in_south_valid = 1'b0; out_south_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_val("rst_counts", {east_count, north_count, south_count}, 256'd0);
        check_val("rst_busy", busy, 256'd0);
        check_val("rst_valids", {out_east_valid, out_north_valid, out_south_valid}, 256'd0);
        check_val("rst_out_east", out_to_east, 256'd0);
        check_val("rst_out_south", out_to_south, 256'd0);

        // 1: single word latency through east
        ap_start = 1'b1; out_east_ready = 1'b1;
        in_from_east = 132'hA5; in_east_valid = 1'b1;
        #1;
        check_val("t1_in_ready", in_east_ready, 256'd1);
        check_val("t1_no_fallthru", out_east_valid, 256'd0);
        tick();
        in_east_valid = 1'b0;
        check_val("t1_valid_c1", out_east_valid, 256'd1);
        check_val("t1_data_c1", out_to_east, 256'hA5);
        check_val("t1_count_c1", east_count, 256'd1);
        tick();
        check_val("t1_count_c2", east_count, 256'd0);
        check_val("t1_valid_c2", out_east_valid, 256'd0);
        check_val("t1_hold_last", out_to_east, 256'hA5);

        // 2: north fill to full, stall word 5, then drain with wrap
        out_north_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_from_north = NW'(k); in_north_valid = 1'b1;
            #1;
            check_val("t2_ready_fill", in_north_ready, 256'd1);
            tick();
        end
        in_from_north = NW'(5);
        #1;
        check_val("t2_full_ready", in_north_ready, 256'd0);
        check_val("t2_full_count", north_count, 256'd4);
        tick();
        check_val("t2_held_count", north_count, 256'd4);
        check_val("t2_held_head", out_to_north, 256'd1);
        out_north_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_north_valid) got.push_back(out_to_north);
            if (in_north_valid && in_north_ready) begin
                tick();
                in_north_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check_val("t2_n_out", got.size(), 256'd5);
        for (int k = 0; k < 5 && k < got.size(); k++) check_val("t2_order", got[k], 256'(k + 1));
        check_val("t2_count_end", north_count, 256'd0);

        // 3: south held at two with simultaneous push/pop
        out_south_ready = 1'b0;
        in_south_valid = 1'b1;
        in_from_south = SW'(10); tick();
        in_from_south = SW'(11); tick();
        check_val("t3_count_init", south_count, 256'd2);
        out_south_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_from_south = SW'(12 + i);
            #1;
            check_val("t3_head", out_to_south, 256'(10 + i));
            check_val("t3_both_hs", {in_south_ready, out_south_valid}, 256'd3);
            tick();
            check_val("t3_count", south_count, 256'd2);
        end
        in_south_valid = 1'b0;
        check_val("t3_tail0", out_to_south, 256'd20);
        tick();
        check_val("t3_tail1", out_to_south, 256'd21);
        tick();
        check_val("t3_drained", south_count, 256'd0);

        // 4: east stalled full while north streams
        out_east_ready = 1'b0; in_east_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_from_east = EW'(32'hE0 + k); tick();
        end
        in_east_valid = 1'b0;
        check_val("t4_east_full", east_count, 256'd4);
        out_north_ready = 1'b1; in_north_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_from_north = NW'(32'h100 + i);
            #1;
            check_val("t4_n_ready", in_north_ready, 256'd1);
            if (i > 0) check_val("t4_n_stream", {out_north_valid, out_to_north[15:0]}, {239'd0, 1'b1, 16'(16'h100 + i - 1)});
            tick();
            check_val("t4_e_head", out_to_east, 256'hE0);
            check_val("t4_e_count", east_count, 256'd4);
        end
        in_north_valid = 1'b0;
        check_val("t4_n_last", out_to_north, 256'h107);
        tick();
        check_val("t4_n_empty", north_count, 256'd0);
        out_east_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_val("t4_e_drain", out_to_east, 256'(32'hE0 + k));
            tick();
        end
        check_val("t4_e_empty", east_count, 256'd0);

        // 5: ap_start freeze with three south words
        out_south_ready = 1'b0; in_south_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_from_south = SW'(32'h31 + k); tick();
        end
        in_south_valid = 1'b0;
        ap_start = 1'b0; out_south_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("t5_frozen_hs", {out_south_valid, in_south_ready}, 256'd0);
            tick();
            check_val("t5_count", south_count, 256'd3);
            check_val("t5_busy", busy, 256'd1);
        end
        ap_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("t5_drain", {out_south_valid, out_to_south[15:0]}, {239'd0, 1'b1, 16'(16'h31 + k)});
            tick();
        end
        check_val("t5_empty", south_count, 256'd0);

        // 6: reset discards three stored east words
        out_east_ready = 1'b0; in_east_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_from_east = EW'(32'h61 + k); tick();
        end
        check_val("t6_pre_count", east_count, 256'd3);
        in_from_east = EW'(32'h64);
        reset = 1'b1;
        tick();
        in_east_valid = 1'b0;
        check_val("t6_counts", {east_count, north_count, south_count}, 256'd0);
        check_val("t6_valid", out_east_valid, 256'd0);
        check_val("t6_busy", busy, 256'd0);
        check_val("t6_data", out_to_east, 256'd0);
        reset = 1'b0; out_east_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t6_no_stale", {out_east_valid, out_to_east}, 256'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
